// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: data width, line idle level and FSM state encoding.
package uart_pkg;

  localparam int   UART_DATA_W = 8;
  localparam logic LINE_IDLE   = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts BAUD_DIV clocks per bit and flags the last one with bit_tick.
module uart_baud_gen #(
  parameter int BAUD_DIV = 16
) (
  input  logic clk_in,
  input  logic sys_rstn,
  input  logic en,
  output logic bit_tick
);

  localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Held at zero while disabled so every frame starts phase-aligned.
  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      cnt <= '0;
    end else if (!en || cnt == CNT_MAX) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_tick = en && (cnt == CNT_MAX);

endmodule

// File: rtl/uart_tx.sv
// Byte-serial UART transmitter (8N1, or 8E1 when UART_TX_PARITY_EN is defined).
// Valid/ready byte input, registered serial line, one-cycle done pulse per frame.
module uart_tx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV  = 16,
  parameter int STOP_BITS = 1
) (
  input  logic                   clk_in,
  input  logic                   sys_rstn,
  input  logic [UART_DATA_W-1:0] tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic                   uart_txd,
  output logic                   tx_busy,
  output logic                   tx_done
);

  localparam logic [2:0] LAST_DATA = 3'(UART_DATA_W - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  uart_state_e            state;
  uart_state_e            next_state;
  logic [UART_DATA_W-1:0] shift_q;
  logic [2:0]             bit_cnt;
  logic                   bit_tick;
  logic                   line_next;
  logic                   accept;
  logic                   txd_q;
  logic                   ready_q;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q;
`endif

  assign accept = tx_valid && ready_q;

  uart_baud_gen #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_gen (
    .clk_in   (clk_in),
    .sys_rstn (sys_rstn),
    .en       (state != IDLE),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    line_next  = LINE_IDLE;
    tx_done    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) next_state = START;
      end
      START: begin
        line_next = 1'b0;
        if (bit_tick) next_state = DATA;
      end
      DATA: begin
        line_next = shift_q[0];
        if (bit_tick && bit_cnt == LAST_DATA) begin
`ifdef UART_TX_PARITY_EN
          next_state = PARITY;
`else
          next_state = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        line_next = parity_q;
        if (bit_tick) next_state = STOP;
      end
`endif
      STOP: begin
        if (bit_tick && bit_cnt == LAST_STOP) begin
          next_state = IDLE;
          tx_done    = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Line and ready are registered from the FSM so the pin never glitches.
  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      shift_q  <= '0;
      bit_cnt  <= '0;
      txd_q    <= LINE_IDLE;
      ready_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      txd_q   <= line_next;
      ready_q <= (next_state == IDLE);
      if (accept) begin
        shift_q  <= tx_data;
`ifdef UART_TX_PARITY_EN
        parity_q <= ^tx_data;
`endif
      end else if (bit_tick && state == DATA) begin
        shift_q <= shift_q >> 1;
      end
      if (next_state != state) begin
        bit_cnt <= '0;
      end else if (bit_tick) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  assign uart_txd = txd_q;
  assign tx_ready = ready_q;
  assign tx_busy  = (state != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: one STOP_BITS=1 instance and one STOP_BITS=2 instance.
module tb_uart_tx;

  localparam int BD = 16;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic            clk_in;
  logic            sys_rstn;
  logic [1:0]      valid;
  logic [1:0][7:0] data;
  wire  [1:0]      ready;
  wire  [1:0]      txd;
  wire  [1:0]      busy;
  wire  [1:0]      done;

  int checks;
  int errors;

  uart_tx #(.BAUD_DIV(BD), .STOP_BITS(1)) dut (
    .clk_in   (clk_in),
    .sys_rstn (sys_rstn),
    .tx_data  (data[0]),
    .tx_valid (valid[0]),
    .tx_ready (ready[0]),
    .uart_txd (txd[0]),
    .tx_busy  (busy[0]),
    .tx_done  (done[0])
  );

  uart_tx #(.BAUD_DIV(BD), .STOP_BITS(2)) dut2 (
    .clk_in   (clk_in),
    .sys_rstn (sys_rstn),
    .tx_data  (data[1]),
    .tx_valid (valid[1]),
    .tx_ready (ready[1]),
    .uart_txd (txd[1]),
    .tx_busy  (busy[1]),
    .tx_done  (done[1])
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // mode 0: drop valid after acceptance; 1: keep valid with next byte (back-to-back);
  // 2: keep valid with next byte during the frame, drop it before the frame ends (stall).
  task automatic run_frame(input int u, input logic [7:0] d, input int nstop, input int mode,
                           input logic [7:0] nd, input string tag);
    int         len;
    int         b;
    int         line_err;
    int         stat_err;
    int         done_at;
    int         done_cnt;
    logic       exp_line;
    logic [7:0] got;
    len      = (9 + nstop + ((u == 0 || PAR == 0) ? PAR : PAR)) * BD;
    line_err = 0;
    stat_err = 0;
    done_at  = -1;
    done_cnt = 0;
    got      = 8'h00;
    valid[u] = 1'b1;
    data[u]  = d;
    @(negedge clk_in);
    if (mode == 0) begin
      valid[u] = 1'b0;
      data[u]  = ~d;
    end else begin
      data[u] = nd;
    end
    for (int k = 1; k <= len + 1; k++) begin
      if (k > 1) @(negedge clk_in);
      if (k == len + 1 && mode == 2) valid[u] = 1'b0;
      b = 0;
      if (k < 2) begin
        exp_line = 1'b1;
      end else begin
        b = (k - 2) / BD;
        if (b == 0)                  exp_line = 1'b0;
        else if (b <= 8)             exp_line = d[b-1];
        else if (PAR == 1 && b == 9) exp_line = ^d;
        else                         exp_line = 1'b1;
      end
      if (txd[u] !== exp_line) line_err++;
      if (k >= 2 && ((k - 2) % BD) == BD / 2 && b >= 1 && b <= 8) got[b-1] = txd[u];
      if (busy[u] !== (k <= len)) stat_err++;
      if (ready[u] !== (k > len)) stat_err++;
      if (done[u] === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
    end
    check_output({tag, "_line"}, line_err, 0);
    check_output({tag, "_status"}, stat_err, 0);
    check_output({tag, "_done_cycle"}, done_at, len);
    check_output({tag, "_done_count"}, done_cnt, 1);
    check_output({tag, "_byte"}, {24'h0, got}, {24'h0, d});
  endtask

  task automatic apply_idle(input int u, input int cycles, input string tag);
    int err;
    err = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk_in);
      if (busy[u] !== 1'b0 || txd[u] !== 1'b1 || done[u] !== 1'b0 || ready[u] !== 1'b1) err++;
    end
    check_output(tag, err, 0);
  endtask

  initial begin
    int done_seen;
    checks   = 0;
    errors   = 0;
    valid    = '0;
    data     = '0;
    sys_rstn = 1'b1;
    #1 sys_rstn = 1'b0;
    #2;
    check_output("reset_txd", txd, 2'b11);
    check_output("reset_ready", ready, 2'b11);
    check_output("reset_busy", busy, 2'b00);
    check_output("reset_done", done, 2'b00);
    @(negedge clk_in);
    @(negedge clk_in);
    sys_rstn = 1'b1;
    apply_idle(0, 3, "idle_after_reset");

    $display("[TB] single byte 0x55");
    run_frame(0, 8'h55, 1, 0, 8'h00, "b55");

    $display("[TB] back-to-back 0xA3, 0x0F");
    run_frame(0, 8'hA3, 1, 1, 8'h0F, "bA3");
    run_frame(0, 8'h0F, 1, 0, 8'h00, "b0F");

    $display("[TB] stall with 0x12 while busy");
    run_frame(0, 8'hC6, 1, 2, 8'h12, "stall");
    apply_idle(0, 40, "stall_no_second_frame");

    $display("[TB] reset mid-frame");
    valid[0] = 1'b1;
    data[0]  = 8'hFF;
    @(negedge clk_in);
    valid[0] = 1'b0;
    data[0]  = 8'h00;
    repeat (49) @(negedge clk_in);
    check_output("midreset_busy_before", busy[0], 1'b1);
    #2 sys_rstn = 1'b0;
    #1;
    check_output("midreset_txd", txd[0], 1'b1);
    check_output("midreset_ready", ready[0], 1'b1);
    check_output("midreset_busy", busy[0], 1'b0);
    done_seen = 0;
    repeat (3) begin
      @(negedge clk_in);
      if (done[0] !== 1'b0) done_seen++;
    end
    sys_rstn = 1'b1;
    repeat (20) begin
      @(negedge clk_in);
      if (done[0] !== 1'b0 || txd[0] !== 1'b1) done_seen++;
    end
    check_output("midreset_no_done", done_seen, 0);
    run_frame(0, 8'h81, 1, 0, 8'h00, "b81");

    $display("[TB] two stop bits 0x00");
    run_frame(1, 8'h00, 2, 0, 8'h00, "stop2");

    $display("[TB] parity-sensitive bytes 0x07, 0x03");
    run_frame(0, 8'h07, 1, 0, 8'h00, "b07");
    run_frame(0, 8'h03, 1, 0, 8'h00, "b03");
    apply_idle(0, 5, "final_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Byte-serial UART transmitter peripheral driving the board's uart_txd pin.
- Accepts one byte per valid/ready handshake from the CPU-side bridge/register logic.
- Serializes each byte as 8N1: 1 start bit, 8 data bits LSB-first, then stop bits.
- Raises a one-cycle done pulse at the end of every frame, usable as an interrupt source.

Parameters:
- BAUD_DIV, 16, clk_in cycles per bit; legal range 2..65535. Simulation uses 16; the board build overrides it.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk_in  input  1  system clock, all logic on its rising edge
- sys_rstn  input  1  reset, asynchronous, active-low
- tx_data  input  8  byte to send; sampled on handshake
- tx_valid  input  1  producer has a byte
- tx_ready  output  1  transmitter can accept a byte
- uart_txd  output  1  serial line, idle high
- tx_busy  output  1  frame in progress
- tx_done  output  1  one-cycle pulse at end of last stop bit

Behaviour:
- Reset (sys_rstn=0, takes effect immediately, asynchronous):
  - uart_txd=1, tx_ready=1, tx_busy=0, tx_done=0.
  - FSM goes to IDLE; bit counter and baud counter clear to 0.
  - An asserted reset mid-frame aborts the frame; the line returns high at once and the partial byte is discarded.
- FSM states:
  - IDLE: uart_txd=1, tx_ready=1. On a clock edge with tx_valid&tx_ready: latch tx_data into the shift register, go to START.
  - START: uart_txd=0 for BAUD_DIV cycles, then go to DATA.
  - DATA: 8 bit periods of BAUD_DIV cycles each. uart_txd=shift[0]; shift right at the end of each period. Bit index 0..7; after bit 7, go to STOP (or PARITY, see Optional Feature).
  - STOP: uart_txd=1 for STOP_BITS*BAUD_DIV cycles. In the final cycle assert tx_done for exactly one cycle; next state is IDLE.
- Timing:
  - Handshake latency: uart_txd falls on the first clk_in edge after the accepting edge.
  - Frame length: (10+STOP_BITS-1)*BAUD_DIV cycles, counted from the accepting edge to re-entry into IDLE.
- Handshake:
  - tx_ready is registered: high only in IDLE, low from the cycle after acceptance.
  - tx_valid may be held high continuously. Bytes are then accepted back-to-back with exactly one IDLE cycle between frames (stop bit, one idle cycle, start bit).
  - tx_data must not be assumed stable after acceptance.
- Status outputs:
  - tx_busy = FSM not IDLE.
  - tx_done and the acceptance of a new byte may occur on adjacent cycles; they are never in the same cycle.
- Baud counter:
  - Width $clog2(BAUD_DIV). Counts 0..BAUD_DIV-1, wraps to 0 and asserts an internal bit_tick.
  - Held at 0 in IDLE, so each frame starts phase-aligned.
- tx_valid asserted while tx_ready=0 has no effect. The byte is not queued.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state follows DATA and drives even parity (XOR of the 8 latched bits) for BAUD_DIV cycles. Frame becomes 8E1 and is one bit period longer.
- Undefined: no PARITY state exists; frame is 8N1 exactly as specified above.

Decomposition:
- Shared package uart_pkg:
  - state encoding localparams: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4
  - UART_DATA_W=8
  - line idle level constant
- One natural sub-module, uart_baud_gen: parameter BAUD_DIV; inputs clk_in, sys_rstn, en; output bit_tick. A future uart_rx reuses it.

Test Plan:
- Single byte (BAUD_DIV=16): send 0x55 on one handshake. uart_txd must show, every 16 cycles: 0, then 1,0,1,0,1,0,1,0, then 1. tx_done pulses at cycle 160 after acceptance; tx_busy is high for cycles 1..160.
- Back-to-back: hold tx_valid=1 with 0xA3, then 0x0F. The second start bit falls exactly 1 cycle after tx_done. Decoded bytes are 0xA3, 0x0F; tx_ready pulses high for exactly 1 cycle between frames.
- Reset mid-frame: send 0xFF, drive sys_rstn=0 at cycle 50. uart_txd=1 and tx_ready=1 in the same cycle with no clock edge; no tx_done pulse. After release, a send of 0x81 produces a clean frame.
- Stall: assert tx_valid with 0x12 while busy. No second frame and no corruption of the current byte on the line.
- STOP_BITS=2: send 0x00. The line stays high for 32 cycles after bit 7; tx_done fires at cycle 176.
- UART_TX_PARITY_EN defined: send 0x07 and the parity bit is 1; send 0x03 and the parity bit is 0. Frame length is 176 cycles.
